// File: rtl/program_memory.sv
// Instruction store: single-cycle registered fetch port plus a streaming loader that fills from address 0.
// Fetch latency 1 cycle; loads always accepted while busy, fetches ignored during a load.
module program_memory #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iFetch,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oValid,
    input  logic                  iLoadStart,
    input  logic [DATA_WIDTH-1:0] iLoadData,
    input  logic                  iLoadValid,
    input  logic                  iLoadLast,
    output logic                  oLoadReady,
    output logic [ADDR_WIDTH:0]   oLoadCount,
    output logic                  oLoadError,
    output logic                  oBusy
);

    localparam logic [0:0] READY = 1'b0;
    localparam logic [0:0] LOAD  = 1'b1;

    localparam int                  IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    // Power-up contents only; reset deliberately leaves the array alone.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1] = '{default: DEFAULT_WORD};

    logic [0:0]            state;
    logic [ADDR_WIDTH:0]   ptr;
    logic                  load_err;
    logic                  in_range;
    logic                  room;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rd_word;

    assign in_range = {1'b0, iAddress} < DEPTH_L;
    assign room     = ptr < DEPTH_L;
    // A restart wins over a word presented in the same cycle.
    assign wr_en    = (state == LOAD) && !iLoadStart && iLoadValid && room;
    assign rd_word  = in_range ? mem[iAddress[IW-1:0]] : DEFAULT_WORD;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr[IW-1:0]] <= iLoadData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= READY;
            ptr          <= '0;
            load_err     <= 1'b0;
            oInstruction <= DEFAULT_WORD;
            oValid       <= 1'b0;
        end else begin
            oValid <= 1'b0;
            if (state == READY) begin
                if (iFetch) begin
                    oInstruction <= rd_word;
                    oValid       <= 1'b1;
                end
                if (iLoadStart) begin
                    state    <= LOAD;
                    ptr      <= '0;
                    load_err <= 1'b0;
                end
            end else begin
                if (iLoadStart) begin
                    ptr      <= '0;
                    load_err <= 1'b0;
                end else if (iLoadValid) begin
                    if (room) begin
                        ptr <= ptr + ONE;
                    end else begin
                        load_err <= 1'b1;
                    end
                    if (iLoadLast) begin
                        state <= READY;
                    end
                end
            end
        end
    end

    // The write pointer doubles as the word count of the current load.
    assign oLoadCount = ptr;
    assign oLoadError = load_err;
    assign oLoadReady = (state == LOAD);
    assign oBusy      = (state == LOAD);

endmodule

// File: tb/tb_program_memory.sv
// Drives a default-size and a 4-word instance with identical stimulus; a scoreboard
// monitor compares each against an abstract model of the load/fetch rules.
module tb_program_memory;

    localparam logic [27:0] DEF = 28'h0;

    typedef struct {
        int          cyc;
        logic [27:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch = 1'b0;
    logic [15:0] addr = '0;
    logic        lstart = 1'b0;
    logic [27:0] ldata = '0;
    logic        lvalid = 1'b0;
    logic        llast = 1'b0;

    logic [27:0] ins   [2];
    logic        vld   [2];
    logic        lrdy  [2];
    logic [16:0] lcnt  [2];
    logic        lerr  [2];
    logic        busy  [2];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    // Reference model state
    logic [27:0] m_mem  [2][256];
    int          m_ptr  [2];
    bit          m_busy [2];
    bit          m_err  [2];
    logic [27:0] m_last [2];
    int          m_depth[2] = '{256, 4};
    exp_t        q0[$];
    exp_t        q1[$];

    program_memory u_big (
        .clk(clk), .rst(rst), .iFetch(fetch), .iAddress(addr),
        .oInstruction(ins[0]), .oValid(vld[0]),
        .iLoadStart(lstart), .iLoadData(ldata), .iLoadValid(lvalid), .iLoadLast(llast),
        .oLoadReady(lrdy[0]), .oLoadCount(lcnt[0]), .oLoadError(lerr[0]), .oBusy(busy[0])
    );

    program_memory #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .iFetch(fetch), .iAddress(addr),
        .oInstruction(ins[1]), .oValid(vld[1]),
        .iLoadStart(lstart), .iLoadData(ldata), .iLoadValid(lvalid), .iLoadLast(llast),
        .oLoadReady(lrdy[1]), .oLoadCount(lcnt[1]), .oLoadError(lerr[1]), .oBusy(busy[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k]  = 0;
            m_busy[k] = 0;
            m_err[k]  = 0;
            m_last[k] = DEF;
        end
        q0.delete();
        q1.delete();
    endtask

    // One clock of stimulus: drive at negedge, advance the model to the post-edge state.
    task automatic step(input bit f, input logic [15:0] a, input bit ls, input bit lv,
                        input logic [27:0] ld, input bit ll);
        exp_t e;
        @(negedge clk);
        fetch = f; addr = a; lstart = ls; lvalid = lv; ldata = ld; llast = ll;
        for (int k = 0; k < 2; k++) begin
            if (!m_busy[k]) begin
                if (f) begin
                    e.cyc = cyc + 1;
                    e.dat = (int'(a) < m_depth[k]) ? m_mem[k][a[7:0]] : DEF;
                    m_last[k] = e.dat;
                    push_exp(k, e);
                end
                if (ls) begin
                    m_busy[k] = 1;
                    m_ptr[k]  = 0;
                    m_err[k]  = 0;
                end
            end else if (ls) begin
                m_ptr[k] = 0;
                m_err[k] = 0;
            end else if (lv) begin
                if (m_ptr[k] < m_depth[k]) begin
                    m_mem[k][m_ptr[k]] = ld;
                    m_ptr[k]++;
                end else begin
                    m_err[k] = 1;
                end
                if (ll) m_busy[k] = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0);
    endtask

    task automatic check_out(input int k);
        exp_t e;
        bit   have;
        have = 0;
        if (k == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1; end
        if (k == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1; end
        chk($sformatf("valid[%0d]", k), 32'(vld[k]), 32'(have));
        chk($sformatf("instr[%0d]", k), 32'(ins[k]), have ? 32'(e.dat) : 32'(m_last[k]));
        chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(m_busy[k]));
        chk($sformatf("ready[%0d]", k), 32'(lrdy[k]), 32'(m_busy[k]));
        chk($sformatf("count[%0d]", k), 32'(lcnt[k]), 32'(m_ptr[k]));
        chk($sformatf("error[%0d]", k), 32'(lerr[k]), 32'(m_err[k]));
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            check_out(0);
            check_out(1);
        end
    end

    task automatic check_reset_values(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_instr[%0d]", tag, k), 32'(ins[k]), 32'(DEF));
            chk($sformatf("%s_valid[%0d]", tag, k), 32'(vld[k]), 0);
            chk($sformatf("%s_ready[%0d]", tag, k), 32'(lrdy[k]), 0);
            chk($sformatf("%s_busy[%0d]", tag, k), 32'(busy[k]), 0);
            chk($sformatf("%s_count[%0d]", tag, k), 32'(lcnt[k]), 0);
            chk($sformatf("%s_error[%0d]", tag, k), 32'(lerr[k]), 0);
        end
    endtask

    initial begin
        logic [27:0] wa;
        logic [27:0] wb;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) m_mem[k][i] = DEF;
        model_reset();

        // Power-on reset
        #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        check_reset_values("por");
        @(negedge clk); rst = 1'b0;

        // First fetch right after reset, then a 3-word load read back with no bubbles
        step(1, 16'd0, 0, 0, '0, 0);
        step(0, '0, 1, 0, '0, 0);
        step(0, '0, 0, 1, 28'h1000001, 0);
        step(0, '0, 0, 1, 28'h2000002, 0);
        step(0, '0, 0, 1, 28'h3000003, 1);
        step(1, 16'd0, 0, 0, '0, 0);
        step(1, 16'd1, 0, 0, '0, 0);
        step(1, 16'd2, 0, 0, '0, 0);
        @(posedge clk); #2;
        chk("req037_valid", 32'(vld[0]), 1);
        chk("req037_instr", 32'(ins[0]), 32'h3000003);
        chk("req037_count", 32'(lcnt[0]), 3);
        chk("req037_error", 32'(lerr[0]), 0);
        step(1, 16'd256, 0, 0, '0, 0);
        @(posedge clk); #2;
        chk("req038_instr", 32'(ins[0]), 32'(DEF));
        chk("req038_valid", 32'(vld[0]), 1);

        // Overflow on the 4-word instance; fetch + start together
        step(1, 16'd1, 1, 0, '0, 0);
        for (int i = 1; i <= 6; i++) step(0, '0, 0, 1, 28'(i), i == 6);
        @(posedge clk); #2;
        chk("req039_count", 32'(lcnt[1]), 4);
        chk("req039_error", 32'(lerr[1]), 1);
        chk("req039_busy", 32'(busy[1]), 0);
        chk("req039_bigcount", 32'(lcnt[0]), 6);
        for (int i = 0; i < 5; i++) step(1, 16'(i), 0, 0, '0, 0);

        // Fetches ignored mid-load, stray last, restart discarding a word
        step(0, '0, 1, 0, '0, 0);
        step(1, 16'd0, 0, 0, '0, 1);
        @(posedge clk); #2;
        chk("req040_valid", 32'(vld[0]), 0);
        chk("req040_busy", 32'(busy[0]), 1);
        chk("req040_instr", 32'(ins[0]), 32'(m_last[0]));
        step(1, 16'd2, 0, 1, 28'hABCDEF1, 0);
        step(0, '0, 1, 1, 28'hDEADBEE, 0);
        step(0, '0, 0, 1, 28'h0C0FFEE, 1);
        for (int i = 0; i < 3; i++) step(1, 16'(i), 0, 0, '0, 0);

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 7)),
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 9) < 6,
                 28'($urandom),
                 $urandom_range(0, 9) == 0);
        end
        step(0, '0, 0, 1, 28'h1, 1);
        idle(2);

        // Reset in the middle of a load
        wa = 28'h0AAAAA1;
        wb = 28'h0BBBBB2;
        step(0, '0, 1, 0, '0, 0);
        step(0, '0, 0, 1, wa, 0);
        step(0, '0, 0, 1, wb, 0);
        step(0, '0, 0, 0, '0, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_values("midrst");
        @(negedge clk);
        fetch = 0; lstart = 0; lvalid = 0; llast = 0;
        @(negedge clk); rst = 1'b0;
        step(1, 16'd0, 0, 0, '0, 0);
        step(1, 16'd1, 0, 0, '0, 0);
        step(1, 16'd2, 0, 0, '0, 0);
        @(posedge clk); #2;
        chk("req041_addr2", 32'(ins[0]), 32'(m_mem[0][2]));
        idle(3);

        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
